// File: rtl/seq_elem_checker.sv
// Stimulus-and-response engine for latch / async-DFF / sync-DFF channels:
// drives an 8-step {rstn, d} sequence, samples q at the end of each step, reports errors.
module seq_elem_checker #(
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] q_i,
  output logic       d_o,
  output logic       rstn_o,
  output logic [2:0] step_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] err_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_DRIVE = 8'(STEP_CYCLES - 2);

  state_t     state_r;
  logic [7:0] cyc_r;
  logic [2:0] step_r;
  logic [1:0] vec_s;
  logic [2:0] mism_s;
  logic [4:0] sum_s;
  logic [3:0] sat_cnt_s;

  // Vector table in {rstn, d} order.
  function automatic logic [1:0] vec_of(input logic [2:0] s);
    logic [1:0] v;
    case (s)
      3'd0, 3'd1: v = 2'b00;
      3'd2, 3'd3: v = 2'b10;
      3'd4, 3'd5: v = 2'b11;
      3'd6:       v = 2'b10;
      3'd7:       v = 2'b11;
      default:    v = 2'b00;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Mismatch vector against the expected q and the saturating error sum.
  always_comb begin
    vec_s  = vec_of(step_r);
    mism_s = q_i ^ {3{vec_s[1] & vec_s[0]}};
    sum_s  = {1'b0, err_cnt} + {3'b000, popcnt3(mism_s)};
    if (sum_s[4]) begin
      sat_cnt_s = 4'hF;
    end else begin
      sat_cnt_s = sum_s[3:0];
    end
  end

  // Sequencer FSM; outputs are registered one cycle behind the state so start->vector takes two edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cyc_r    <= 8'd0;
      step_r   <= 3'd0;
      err_cnt  <= 4'd0;
      err_mask <= 3'b000;
      d_o      <= 1'b0;
      rstn_o   <= 1'b0;
      step_o   <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      busy   <= (state_r == DRIVE) || (state_r == CHECK);
      done   <= (state_r == DONE);
      pass   <= (state_r == DONE) && (err_cnt == 4'd0);
      step_o <= step_r;
      if ((state_r == DRIVE) || (state_r == CHECK)) begin
        rstn_o <= vec_s[1];
        d_o    <= vec_s[0];
      end else begin
        rstn_o <= 1'b0;
        d_o    <= 1'b0;
      end

      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r  <= DRIVE;
            step_r   <= 3'd0;
            cyc_r    <= 8'd0;
            err_cnt  <= 4'd0;
            err_mask <= 3'b000;
          end else begin
            state_r <= state_r;
          end
        end
        DRIVE: begin
          if (cyc_r == LAST_DRIVE) begin
            cyc_r   <= 8'd0;
            state_r <= CHECK;
          end else begin
            cyc_r <= cyc_r + 8'd1;
          end
        end
        CHECK: begin
          err_cnt  <= sat_cnt_s;
          err_mask <= err_mask | mism_s;
          if (step_r == 3'd7) begin
            state_r <= DONE;
          end else begin
            step_r  <= step_r + 3'd1;
            state_r <= DRIVE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_elem_checker.sv
// Directed bench for seq_elem_checker: table of fault modes plus reset/abort/restart sequences.
module tb_seq_elem_checker;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] q_i;
  logic       d_o, rstn_o, busy, done, pass;
  logic [2:0] step_o, err_mask;
  logic [3:0] err_cnt;
  int         checks = 0;
  int         failures = 0;
  int         mode = 0;  // 0 ideal, 1 q[1] stuck-1, 2 all stuck-0, 3 inverted

  always #5 clk = ~clk;

  seq_elem_checker #(.STEP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .q_i(q_i),
    .d_o(d_o), .rstn_o(rstn_o), .step_o(step_o), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt), .err_mask(err_mask)
  );

  // Bench-side model of the three storage elements, with fault injection.
  always_comb begin
    logic e;
    e = rstn_o & d_o;
    case (mode)
      1:       q_i = {e, 1'b1, e};
      2:       q_i = 3'b000;
      3:       q_i = {3{~e}};
      default: q_i = {3{e}};
    endcase
  end

  typedef struct {
    int         mode;
    logic [3:0] cnt;
    logic [2:0] mask;
    logic       pass;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " outs"}, {d_o, rstn_o, step_o, busy, done, pass, err_cnt, err_mask}, 0);
  endtask

  // Starts a run (edge E) and checks the full trace up to done at E+33.
  task automatic run(input bit poke_busy);
    logic [1:0] tv [8];
    tv = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_E", busy, 0);
    for (int n = 1; n <= 32; n++) begin
      if (poke_busy && n == 10) start = 1'b1;
      if (poke_busy && n == 11) start = 1'b0;
      tick();
      chk("busy_in_run", busy, 1);
      chk("done_in_run", done, 0);
      chk("step_o", step_o, (n - 1) / 4);
      chk("vector", {rstn_o, d_o}, tv[(n - 1) / 4]);
      if (n == 1) chk("cleared_at_start", {err_cnt, err_mask}, 0);
    end
    tick();
    chk("done_at_E33", done, 1);
    chk("busy_at_E33", busy, 0);
    chk("step_o_done", step_o, 7);
    chk("vector_done", {rstn_o, d_o}, 0);
  endtask

  initial begin
    tbl[0] = '{0, 4'd0,  3'b000, 1'b1};
    tbl[1] = '{1, 4'd5,  3'b010, 1'b0};
    tbl[2] = '{2, 4'd9,  3'b111, 1'b0};
    tbl[3] = '{3, 4'd15, 3'b111, 1'b0};

    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk_idle("post_reset");

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      run(i == 1);
      chk("pass", pass, tbl[i].pass);
      chk("err_cnt", err_cnt, tbl[i].cnt);
      chk("err_mask", err_mask, tbl[i].mask);
      tick();
      tick();
      chk("held", {done, pass, err_cnt, err_mask}, {1'b1, tbl[i].pass, tbl[i].cnt, tbl[i].mask});
    end

    // Restart from DONE after the failing saturation run.
    mode = 0;
    run(1'b0);
    chk("restart_pass", pass, 1);
    chk("restart_cnt", {err_cnt, err_mask}, 0);

    // Abort during step 3 with faults active.
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 14; n++) tick();
    chk("abort_step", step_o, 3);
    rst = 1'b1;
    tick();
    chk_idle("abort");
    rst = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    chk_idle("abort_stays_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_elem_checker.md
# seq_elem_checker

Synthesizable stimulus-and-response engine for the storage-element set (`d_latch`, `dff_asyn`, `dff_syn`). It is the DUT-facing counterpart of our simulation benches:

- It drives a fixed 8-step `{rst_n, d}` vector sequence into up to three storage elements.
- It samples their `q` outputs at the end of each step and compares them against an internal expected model.
- It reports per-channel mismatches, an error count and pass/fail, so the same check runs on a board.

## Interface

Parameters:
- `STEP_CYCLES`, default 4: clock cycles per vector step. Legal range 2..255.

Ports:
- `clk`  input  1  — single clock, all logic on rising edge.
- `rst`  input  1  — reset is synchronous and active-high.
- `start`  input  1  — single-cycle run request; sampled only in `IDLE` or `DONE`.
- `q_i`  input  3  — DUT outputs: [0] latch, [1] async-reset DFF, [2] sync-reset DFF.
- `d_o`  output  1  — data driven to all DUTs, registered.
- `rstn_o`  output  1  — active-low reset driven to all DUTs, registered.
- `step_o`  output  3  — current vector index.
- `busy`  output  1  — high in `DRIVE` and `CHECK`.
- `done`  output  1  — high in `DONE`.
- `pass`  output  1  — valid while `done`; equals `err_cnt == 0`.
- `err_cnt`  output  4  — mismatch count, saturating at 15.
- `err_mask`  output  3  — sticky per-channel mismatch flags.

## Operation

Vector table, indexed by step 0..7, in `{rstn_o, d_o}` order: 00, 00, 10, 10, 11, 11, 10, 11.

Expected `q` for every channel is `rstn_o ? d_o : 0`. Per step this gives 0,0,0,0,1,1,0,1.

FSM states `IDLE`, `DRIVE`, `CHECK`, `DONE`:
- **`IDLE`**: `rstn_o` = 0, `d_o` = 0. If `start` = 1, go to `DRIVE` with step = 0, cycle counter = 0, and `err_cnt` / `err_mask` cleared.
- **`DRIVE`**: the vector for the current step is applied. Stay for `STEP_CYCLES`-1 cycles, then go to `CHECK`.
- **`CHECK`** (1 cycle): the vector is still held. Compare `q_i` against the expected value bitwise.
  - Each mismatching bit adds 1 to `err_cnt`, saturating at 15. Up to 3 can be added per check.
  - Each mismatching bit sets its `err_mask` bit.
  - Then: if step == 7 go to `DONE`, else step+1 and go to `DRIVE`.
- **`DONE`**: `rstn_o` = 0, `d_o` = 0. `done` = 1, and `pass`, `err_cnt`, `err_mask` are held. If `start` = 1, behave as `IDLE` + `start` (clear the counters and restart at step 0).

Further rules:
- `start` while `busy` is ignored.
- `rst` overrides everything; a run in progress is aborted with no partial result kept.
- `step_o` shows the current step in `DRIVE`/`CHECK`; it is 0 in `IDLE`, and 7 in `DONE`.

## Timing

- **Reset values** (one `clk` edge with `rst` = 1): state `IDLE`, `d_o` = 0, `rstn_o` = 0, `step_o` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0, `err_mask` = 0.
- **Start:** `start` is sampled at edge E. The step-0 vector and `busy` appear after edge E+1.
- **Step length:** each step occupies exactly `STEP_CYCLES` cycles. The vector changes only on step boundaries.
- **Sampling point:** `q_i` is sampled at the edge ending the `CHECK` cycle. That is `STEP_CYCLES`-1 cycles after the vector was applied, so synchronous-reset and async-reset elements have both settled.
- **Completion:** `done` rises after edge E+1+8·`STEP_CYCLES` (edge E+33 for the default). `busy` falls on the same edge.
- **Reset mid-run:** `rst` asserted at edge R gives all reset values after R. `rstn_o` is already 0 after R, so the DUTs are held in reset.
- **Outputs:** all outputs are registered, with no combinational path from `q_i` or `start`.

## Test plan

- **Reset:** hold `rst` for 2 cycles. All outputs read 0; `start` is ignored while `rst` = 1.
- **Ideal model:** bench `q_i` = 3 copies of (`rstn_o` ? `d_o` : 0), `STEP_CYCLES` = 4, start pulse at edge E.
  - `d_o`/`rstn_o` follow the table in 4-cycle steps.
  - `done` = 1 at E+33, with `pass` = 1, `err_cnt` = 0, `err_mask` = 000.
- **Stuck-at-1 channel:** `q_i[1]` stuck at 1, others ideal. Errors at steps 0,1,2,3,6, giving `err_cnt` = 5, `err_mask` = 010, `pass` = 0.
- **All stuck-at-0:** `q_i` = 000. Errors at steps 4,5,7 on 3 bits, giving `err_cnt` = 9, `err_mask` = 111.
- **Saturation:** `q_i` = inverted expected on all bits. That is 24 mismatches, so `err_cnt` = 15, `err_mask` = 111.
- **Control corner cases:**
  - Assert `rst` during step 3: next cycle is `IDLE` with all outputs 0.
  - `start` pulsed while `busy`: no effect, and timing stays unchanged.
  - `start` in `DONE` after a failing run: `err_cnt`/`err_mask` clear and step 0 restarts.
